// File: rtl/dac_channel_scheduler_if.sv
// dac_channel_scheduler_if
// Bundles the signals between the DAC channel scheduler and the blocks around it.
// The blocks around it are the UART register decoder, the external SPI shifter
// and the 74HC4051 mux pins.
//
// Signals:
//   en        scheduler enable
//   wr_valid  one-cycle shadow-write strobe
//   wr_ch     channel index of the write
//   wr_data   12-bit DAC code of the write
//   spi_start one-cycle pulse that starts an SPI frame
//   spi_word  16-bit AD5320 frame, held stable while the frame is shifted out
//   spi_done  one-cycle pulse from the shifter when the frame has finished
//   mux_pos   HC4051 select
//   mux_inh   HC4051 inhibit (1 = all outputs disconnected)
//   busy      scheduler not idle
//   cur_ch    channel currently or last serviced
//
// Modports:
//   slave  - the scheduler side
//   master - the environment side (register decoder / shifter / bench)
interface dac_channel_scheduler_if #(
  parameter int N_CH = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic            en;
  logic            wr_valid;
  logic [CH_W-1:0] wr_ch;
  logic [11:0]     wr_data;
  logic            spi_start;
  logic [15:0]     spi_word;
  logic            spi_done;
  logic [CH_W-1:0] mux_pos;
  logic            mux_inh;
  logic            busy;
  logic [CH_W-1:0] cur_ch;

  modport slave (
    input  en, wr_valid, wr_ch, wr_data, spi_done,
    output spi_start, spi_word, mux_pos, mux_inh, busy, cur_ch
  );

  modport master (
    output en, wr_valid, wr_ch, wr_data, spi_done,
    input  spi_start, spi_word, mux_pos, mux_inh, busy, cur_ch
  );
endinterface

// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler
// Time-shares one 12-bit AD5320 DAC across N_CH sample-and-hold outputs.
// The outputs are selected through a 74HC4051 analogue demux. Each channel has
// a shadow code register written by the UART register decoder. Newly written
// (dirty) channels are refreshed first. When no channel is dirty, the channels
// are refreshed in round-robin order.
//
// Refresh of one channel:
//   1. PICK     - choose the channel and move the mux select while inhibited.
//   2. LOAD     - pulse spi_start with the frame for that channel.
//   3. WAIT_SPI - wait for the shifter to report spi_done.
//   4. SETTLE   - let the DAC output settle with the mux still inhibited.
//   5. HOLD     - connect the mux so the hold capacitor charges.
//   6. RELEASE  - inhibit again before anything else changes.
//
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    scheduler side of dac_channel_scheduler_if (write port, SPI
//          handshake, mux controls, status)
module dac_channel_scheduler #(
  parameter int N_CH          = 8,
  parameter int SETTLE_CYCLES = 64,
  parameter int HOLD_CYCLES   = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dac_channel_scheduler_if.slave   bus
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int MAX_CNT = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_LOAD,
    S_WAIT_SPI,
    S_SETTLE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [CH_W-1:0] mux_pos_q, mux_pos_d;
  logic            mux_inh_q, mux_inh_d;
  logic            busy_q, busy_d;
  logic            spi_start_q, spi_start_d;
  logic [15:0]     spi_word_q, spi_word_d;
  logic [N_CH-1:0] dirty_q, dirty_d;
  logic [11:0]     shadow_q [N_CH];
  logic [11:0]     shadow_d [N_CH];

  logic [CH_W-1:0] pick_ch;
  logic [CH_W-1:0] pick_cand;
  logic            pick_found;
  logic [11:0]     pick_code;

  // Channel selection for the next PICK.
  // The search starts one past the current channel and wraps around. The last
  // candidate is the current channel itself, so a channel rewritten while it
  // was being serviced is still found. When nothing is dirty, the result falls
  // back to the plain round-robin successor.
  always_comb begin
    pick_ch    = cur_ch_q + CH_W'(1);
    pick_cand  = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      pick_cand = cur_ch_q + CH_W'(i);
      if (!pick_found && dirty_q[pick_cand]) begin
        pick_ch    = pick_cand;
        pick_found = 1'b1;
      end
    end
  end

  // The frame is captured as the FSM enters LOAD, so spi_word is already valid
  // in the same cycle spi_start is high. A write to the picked channel in that
  // PICK cycle is forwarded. The word therefore matches what shadow[cur_ch]
  // holds during LOAD. Writes from LOAD onwards do not touch the word in flight.
  always_comb begin
    pick_code = shadow_q[pick_ch];
    if (bus.wr_valid && (bus.wr_ch == pick_ch)) begin
      pick_code = bus.wr_data;
    end
  end

  // Next-state and datapath logic.
  // The shadow write is applied after the FSM cases, so a write to the channel
  // whose dirty bit LOAD is clearing wins and leaves the bit set. Registered
  // outputs are derived from the next state, so each output is aligned with
  // the state it belongs to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_ch_d   = cur_ch_q;
    mux_pos_d  = mux_pos_q;
    spi_word_d = spi_word_q;
    dirty_d    = dirty_q;
    shadow_d   = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_PICK;
        end
      end

      S_PICK: begin
        cur_ch_d   = pick_ch;
        mux_pos_d  = pick_ch;
        spi_word_d = {2'b00, 2'b00, pick_code};
        state_d    = S_LOAD;
      end

      S_LOAD: begin
        dirty_d[cur_ch_q] = 1'b0;
        state_d           = S_WAIT_SPI;
      end

      S_WAIT_SPI: begin
        if (bus.spi_done) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        state_d = bus.en ? S_PICK : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.wr_valid) begin
      shadow_d[bus.wr_ch] = bus.wr_data;
      dirty_d[bus.wr_ch]  = 1'b1;
    end
  end

  // Registered outputs.
  // The mux is connected only during HOLD, so break-before-make holds: mux_pos
  // only moves on leaving PICK, which is several states away from HOLD.
  always_comb begin
    spi_start_d = (state_d == S_LOAD);
    mux_inh_d   = (state_d != S_HOLD);
    busy_d      = (state_d != S_IDLE);
  end

  // State register.
  // Reset inhibits the mux at once. It also marks every channel dirty, so all
  // hold capacitors are rewritten with code 0 after reset. cur_ch starts at the
  // last channel so that the first pick lands on channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_ch_q    <= LAST_CH;
      mux_pos_q   <= '0;
      mux_inh_q   <= 1'b1;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_word_q  <= '0;
      dirty_q     <= '1;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_ch_q    <= cur_ch_d;
      mux_pos_q   <= mux_pos_d;
      mux_inh_q   <= mux_inh_d;
      busy_q      <= busy_d;
      spi_start_q <= spi_start_d;
      spi_word_q  <= spi_word_d;
      dirty_q     <= dirty_d;
      shadow_q    <= shadow_d;
    end
  end

  assign bus.spi_start = spi_start_q;
  assign bus.spi_word  = spi_word_q;
  assign bus.mux_pos   = mux_pos_q;
  assign bus.mux_inh   = mux_inh_q;
  assign bus.busy      = busy_q;
  assign bus.cur_ch    = cur_ch_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb_dac_channel_scheduler
// Directed bench for dac_channel_scheduler.
//
// A table of expected service events is checked in order. Each event is a
// channel and its frame, plus optional shadow writes issued during that
// channel's service. Hand-written sequences cover the LOAD/HOLD write corner,
// en dropping mid-sequence, and reset during HOLD. A shifter model answers
// each spi_start with spi_done D cycles later. A monitor watches
// break-before-make, the single-cycle spi_start and the HOLD length.
module tb_dac_channel_scheduler;

  localparam int D      = 20;
  localparam int SETTLE = 64;
  localparam int HOLD   = 256;
  localparam int PERIOD = 1 + 1 + D + SETTLE + HOLD + 1;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] word;
    bit          chk_period;
    int          wr_n;
    logic [2:0]  wr_ch_a;
    logic [11:0] wr_data_a;
    logic [2:0]  wr_ch_b;
    logic [11:0] wr_data_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_channel_scheduler_if #(.N_CH(8)) bus();

  dac_channel_scheduler #(
    .N_CH(8),
    .SETTLE_CYCLES(SETTLE),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_count = 0;
  int   rem = 0;
  int   prev_at = 0;
  int   rel_cyc = 0;
  vec_t tab [21];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ch, input logic [11:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_ch    = ch;
    bus.wr_data  = data;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Shifter model: spi_done is high in the D-th cycle after the spi_start cycle.
  always @(negedge clk) begin
    bus.spi_done = 1'b0;
    if (!rst_n) begin
      rem = 0;
    end else if (bus.spi_start) begin
      rem = D;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) bus.spi_done = 1'b1;
    end
  end

  // Continuous checker for the mux and start-pulse rules.
  logic [2:0] last_pos = 3'd0;
  logic       last_start = 1'b0;
  int         inh_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      inh_run    = 0;
      last_start = 1'b0;
    end else begin
      if (!bus.mux_inh) begin
        checkOutput("mux_pos_stable_while_connected", 32'(bus.mux_pos), 32'(last_pos));
        inh_run++;
      end else if (inh_run > 0) begin
        checkOutput("hold_length", 32'(inh_run), 32'(HOLD));
        inh_run = 0;
      end
      if (bus.spi_start) begin
        start_count++;
        checkOutput("spi_start_while_inhibited", 32'(bus.mux_inh), 32'd1);
        checkOutput("spi_start_single_cycle", 32'(last_start), 32'd0);
      end
      last_start = bus.spi_start;
    end
    last_pos = bus.mux_pos;
  end

  task automatic waitStart(output logic [2:0] ch, output logic [15:0] word, output int at);
    bit ok;
    ok = 1'b0;
    ch = 3'd0;
    word = 16'd0;
    at = cyc;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.spi_start) begin
        ch   = bus.mux_pos;
        word = bus.spi_word;
        at   = cyc;
        ok   = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL spi_start_timeout: got no spi_start expected one within 600 cycles");
    end
  endtask

  task automatic waitInh(input logic level, input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.mux_inh == level) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL mux_inh_timeout: got %0b expected %0b", bus.mux_inh, level);
    end
  endtask

  task automatic checkService(input int idx, input logic [2:0] exp_ch, input logic [15:0] exp_word,
                              input bit chk_period);
    logic [2:0]  ch;
    logic [15:0] word;
    int          at;
    waitStart(ch, word, at);
    checkOutput($sformatf("svc_ch[%0d]", idx), 32'(ch), 32'(exp_ch));
    checkOutput($sformatf("svc_cur_ch[%0d]", idx), 32'(bus.cur_ch), 32'(exp_ch));
    checkOutput($sformatf("svc_word[%0d]", idx), 32'(word), 32'(exp_word));
    if (chk_period) checkOutput($sformatf("svc_period[%0d]", idx), 32'(at - prev_at), 32'(PERIOD));
    else if (idx == 0) checkOutput("reset_to_start_latency", 32'(at - rel_cyc), 32'd2);
    prev_at = at;
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      checkService(i, tab[i].ch, tab[i].word, tab[i].chk_period);
      if (tab[i].wr_n > 0) begin
        repeat (30) @(negedge clk);
        applyStimulus(tab[i].wr_ch_a, tab[i].wr_data_a);
        if (tab[i].wr_n > 1) applyStimulus(tab[i].wr_ch_b, tab[i].wr_data_b);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    int en_cyc;
    logic [2:0]  ch;
    logic [15:0] word;
    int          at;

    // Expected service order for the initial pass, refresh, dirty preemption.
    for (int i = 0; i < 8; i++) begin
      tab[i] = '{3'(i), 16'h0000, (i > 0), 0, 3'd0, 12'h0, 3'd0, 12'h0};
    end
    tab[8]  = '{3'd0, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[9]  = '{3'd1, 16'h0000, 1'b1, 1, 3'd5, 12'hABC, 3'd0, 12'h0};
    tab[10] = '{3'd5, 16'h0ABC, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[11] = '{3'd6, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[12] = '{3'd7, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[13] = '{3'd0, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[14] = '{3'd1, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[15] = '{3'd2, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[16] = '{3'd3, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[17] = '{3'd4, 16'h0000, 1'b1, 2, 3'd3, 12'h100, 3'd6, 12'h200};
    tab[18] = '{3'd6, 16'h0200, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[19] = '{3'd3, 16'h0100, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};
    tab[20] = '{3'd4, 16'h0000, 1'b1, 0, 3'd0, 12'h0,   3'd0, 12'h0};

    bus.en       = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_ch    = 3'd0;
    bus.wr_data  = 12'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_spi_start", 32'(bus.spi_start), 32'd0);
    checkOutput("rst_spi_word", 32'(bus.spi_word), 32'd0);
    checkOutput("rst_mux_pos", 32'(bus.mux_pos), 32'd0);
    checkOutput("rst_mux_inh", 32'(bus.mux_inh), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cur_ch", 32'(bus.cur_ch), 32'd7);

    rst_n   = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    checkOutput("pick_busy", 32'(bus.busy), 32'd1);
    checkOutput("pick_no_start", 32'(bus.spi_start), 32'd0);

    // Initial pass, refresh, dirty preemption, two-write ordering.
    runRows(0, 20);

    // Write in the LOAD cycle and during HOLD of the channel in service.
    waitStart(ch, word, at);
    checkOutput("load_wr_ch", 32'(ch), 32'd5);
    checkOutput("load_wr_word", 32'(word), 32'h0ABC);
    checkOutput("load_wr_period", 32'(at - prev_at), 32'(PERIOD));
    prev_at = at;
    applyStimulus(3'd5, 12'h111);
    repeat (10) @(negedge clk);
    checkOutput("inflight_word_after_load_write", 32'(bus.spi_word), 32'h0ABC);
    waitInh(1'b0, 200);
    repeat (5) @(negedge clk);
    applyStimulus(3'd5, 12'h222);
    checkOutput("inflight_word_after_hold_write", 32'(bus.spi_word), 32'h0ABC);
    checkService(100, 3'd5, 16'h0222, 1'b1);
    checkService(101, 3'd6, 16'h0200, 1'b1);

    // en dropped during SETTLE.
    repeat (30) @(negedge clk);
    checkOutput("settle_busy", 32'(bus.busy), 32'd1);
    checkOutput("settle_inh", 32'(bus.mux_inh), 32'd1);
    bus.en = 1'b0;
    waitInh(1'b0, 100);
    waitInh(1'b1, 300);
    checkOutput("release_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_inh", 32'(bus.mux_inh), 32'd1);
    sc = start_count;
    repeat (400) @(negedge clk);
    checkOutput("idle_no_start", 32'(start_count), 32'(sc));
    checkOutput("idle_still_idle", 32'(bus.busy), 32'd0);

    // Re-enable from IDLE, then reset during HOLD.
    bus.en = 1'b1;
    en_cyc = cyc;
    waitStart(ch, word, at);
    checkOutput("reenable_ch", 32'(ch), 32'd7);
    checkOutput("reenable_word", 32'(word), 32'h0000);
    checkOutput("idle_to_start_latency", 32'(at - en_cyc), 32'd2);
    waitInh(1'b0, 200);
    repeat (10) @(negedge clk);
    sc = start_count;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_inh", 32'(bus.mux_inh), 32'd1);
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_rst_start", 32'(bus.spi_start), 32'd0);
    checkOutput("async_rst_cur_ch", 32'(bus.cur_ch), 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("rst_hold_no_start", 32'(start_count), 32'(sc));
    checkOutput("rst_hold_word", 32'(bus.spi_word), 32'd0);
    rst_n   = 1'b1;
    rel_cyc = cyc;

    // After reset every channel is rewritten with code 0.
    runRows(0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_channel_scheduler.md
Name: dac_channel_scheduler

Overview:
- Sequences the single shared 12-bit AD5320 DAC across 8 sample-and-hold outputs demultiplexed by the 74HC4051.
- Holds a shadow register per channel, written by the UART register decoder.
- Arbitrates which channel is refreshed next: dirty (newly written) channels first, otherwise continuous round-robin refresh.
- Drives an external SPI shifter and the mux select/inhibit with the required settle and hold timing.

Parameters:
- N_CH, 8, number of channels; mux select width is 3 bits.
- SETTLE_CYCLES, 64, clk cycles the DAC output settles with the mux inhibited after an SPI word completes.
- HOLD_CYCLES, 256, clk cycles the mux stays connected to charge the selected hold capacitor.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; when low, the block finishes the current channel, then idles.
- wr_valid  in  1  one-cycle shadow-write strobe.
- wr_ch  in  3  channel index for the write.
- wr_data  in  12  DAC code for the write.
- spi_start  out  1  one-cycle pulse that starts an SPI word transfer.
- spi_word  out  16  AD5320 frame {2'b00, PD=2'b00, code[11:0]}; stable from spi_start until spi_done.
- spi_done  in  1  one-cycle pulse from the shifter when the frame has finished.
- mux_pos  out  3  HC4051 select.
- mux_inh  out  1  HC4051 inhibit; 1 = all outputs disconnected.
- busy  out  1  high in every state except IDLE.
- cur_ch  out  3  channel currently or last serviced.

Behaviour:
Reset (async, rst_n low):
- Shadow registers = 0; dirty[7:0] = 8'hFF, so every channel is written after reset.
- Outputs: spi_start = 0, spi_word = 0, mux_pos = 0, mux_inh = 1, busy = 0, cur_ch = 7 (so the first pick is channel 0).
- State = IDLE; counters = 0.

Shadow write:
- On wr_valid, shadow[wr_ch] <= wr_data and dirty[wr_ch] <= 1, in any state.
- If the same channel's dirty bit is cleared in the same cycle, the set wins.

State machine:
- IDLE: if en, go to PICK next cycle.
- PICK (1 cycle):
  - If any dirty bit is set, choose the first dirty channel searching cur_ch+1, cur_ch+2, … modulo 8.
  - Otherwise choose cur_ch+1 modulo 8 (refresh).
  - Register cur_ch and mux_pos; keep mux_inh = 1.
- LOAD (1 cycle):
  - spi_word <= frame of shadow[cur_ch]; spi_start = 1; dirty[cur_ch] cleared here.
  - A write to cur_ch in this same cycle leaves dirty set (set wins).
  - Go to WAIT_SPI.
- WAIT_SPI: wait for spi_done; a spi_done arriving in the LOAD cycle is ignored. Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles with mux_inh = 1, then go to HOLD.
- HOLD:
  - mux_inh = 0 for exactly HOLD_CYCLES cycles.
  - mux_pos must not change while mux_inh = 0.
  - Then go to RELEASE.
- RELEASE (1 cycle): mux_inh = 1. Next state is PICK if en, else IDLE.

Ordering and timing:
- mux_pos changes only in PICK, i.e. while mux_inh = 1: break-before-make.
- Latency from IDLE with en high: PICK at cycle t+1, spi_start at t+2.
- Channel period with an ideal shifter (spi_done D cycles after spi_start): 1 + 1 + D + SETTLE_CYCLES + HOLD_CYCLES + 1 cycles.
- A write after LOAD of the channel being serviced does not alter the word in flight; the channel is re-serviced later because its dirty bit is set.
- en dropping mid-sequence does not abort: the current channel completes through RELEASE. mux_inh returns to 1 before the block idles.
- Reset mid-sequence: immediate return to reset values; mux_inh = 1 asynchronously.
- Counters are sized to ceil(log2(max parameter + 1)) bits; no wrap occurs inside a state.

Test Plan:
1. Reset release, en = 1, shifter returns spi_done 20 cycles after spi_start → channels serviced 0,1,…,7 (all dirty), each frame carrying code 0. mux_inh low for exactly 256 cycles per channel, then refresh continues 0,1,2… indefinitely.
2. After the initial pass, wr_valid ch=5 data=12'hABC while servicing ch 1 → next PICK selects 5 (not 2); spi_word = 16'h0ABC; then ch 6 refresh follows.
3. Writes ch 3 = 12'h100 and ch 6 = 12'h200 in consecutive cycles while servicing ch 4 → service order 6 then 3 (round-robin from 5); after that, refresh resumes.
4. wr_valid to cur_ch in the LOAD cycle and again during HOLD → the in-flight word is unchanged; the channel is re-picked at the next dirty search with the latest data.
5. en dropped during SETTLE → block completes HOLD and RELEASE, then goes to IDLE with busy = 0 and mux_inh = 1; no further spi_start.
6. rst_n asserted during HOLD → mux_inh = 1 and busy = 0 within the same cycle (async), with no spi_start pulse. After release, all channels are rewritten with code 0.
7. Throughout all scenarios, checker: mux_pos never changes while mux_inh = 0, and spi_start is never asserted outside LOAD.
